// File: rtl/shift_rx_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : shift_rx_4bit
//  Description : Serial receiver for 4-bit frames. Each frame is a start bit
//                (1), four data bits LSB first, an optional even-parity bit
//                and a stop bit (0). Accepted words are registered on Q with
//                valid/rd handshaking, a sticky overrun flag and a
//                one-cycle frame_err pulse for rejected frames.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_rx_4bit #(
    parameter int unsigned PARITY_EN = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       si,
    input  logic       en,
    input  logic       rd,
    output logic [3:0] Q,
    output logic       valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DATA   = 2'd1;
    localparam logic [1:0] c_PARITY = 2'd2;
    localparam logic [1:0] c_STOP   = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [1:0] r_cnt;
    logic [3:0] r_shift;
    logic       r_parity_bad;
    logic [3:0] r_q;
    logic       r_valid;
    logic       r_frame_err;
    logic       r_overrun;

    logic       w_parity_mismatch;
    logic       w_stop_sample;
    logic       w_accept;
    logic       w_reject;

    // Parity comparison only exists when the parity bit is part of the frame.
    generate
        if (PARITY_EN != 0) begin : g_parity_on
            assign w_parity_mismatch = (^r_shift) ^ si;
        end else begin : g_parity_off
            assign w_parity_mismatch = 1'b0;
        end
    endgenerate

    // The stop bit is sampled on the enabled edge while in STOP; the frame is
    // accepted only if the stop bit is 0 and no parity error was recorded.
    assign w_stop_sample = en && (r_state == c_STOP);
    assign w_accept      = w_stop_sample && !si && !r_parity_bad;
    assign w_reject      = w_stop_sample && (si || r_parity_bad);

    // Next-state decode; disabled cycles hold the state. Leaving STOP always
    // lands in IDLE, so a start bit on that same edge is never seen.
    always_comb begin
        w_state_nxt = r_state;
        if (en) begin
            case (r_state)
                c_IDLE:   if (si) w_state_nxt = c_DATA;
                c_DATA:   if (r_cnt == 2'd3) w_state_nxt = (PARITY_EN != 0) ? c_PARITY : c_STOP;
                c_PARITY: w_state_nxt = c_STOP;
                c_STOP:   w_state_nxt = c_IDLE;
                default:  w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Frame sequencing: state, bit counter, shift register and parity flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_cnt        <= 2'd0;
            r_shift      <= 4'd0;
            r_parity_bad <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (en) begin
                case (r_state)
                    c_IDLE: begin
                        if (si) r_cnt <= 2'd0;
                    end
                    c_DATA: begin
                        // New bit enters at the MSB so the first bit ends in bit 0.
                        r_shift <= {si, r_shift[3:1]};
                        r_cnt   <= r_cnt + 2'd1;
                    end
                    c_PARITY: begin
                        r_parity_bad <= w_parity_mismatch;
                    end
                    c_STOP: begin
                        r_parity_bad <= 1'b0;
                    end
                    default: begin
                        r_parity_bad <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Output word, valid/rd handshake, sticky overrun and frame error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q         <= 4'd0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_reject;
            if (w_accept) begin
                r_q     <= r_shift;
                r_valid <= 1'b1;
                // Overwriting an unread word is an overrun unless it is read
                // on this very edge.
                if (r_valid && !rd) r_overrun <= 1'b1;
            end else if (rd && r_valid) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign Q         = r_q;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_rx_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_rx_4bit
//  Description : Scoreboard bench for shift_rx_4bit. One instance without
//                parity and one with parity; expected output events are
//                queued by the stimulus and popped by per-instance monitors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_rx_4bit;

    typedef struct packed {
        logic       err;
        logic [3:0] q;
        logic       vld;
        logic       ovr;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       si0 = 1'b0, en0 = 1'b0, rd0 = 1'b0;
    logic       si1 = 1'b0, en1 = 1'b0, rd1 = 1'b0;
    logic [3:0] q0, q1;
    logic       valid0, valid1, ferr0, ferr1, ovr0, ovr1, busy0, busy1;

    int checks = 0;
    int failures = 0;
    ev_t exp0[$];
    ev_t exp1[$];

    always #5 clk = ~clk;

    shift_rx_4bit #(.PARITY_EN(0)) u_dut0 (
        .clk(clk), .reset(reset), .si(si0), .en(en0), .rd(rd0),
        .Q(q0), .valid(valid0), .frame_err(ferr0), .overrun(ovr0), .busy(busy0)
    );

    shift_rx_4bit #(.PARITY_EN(1)) u_dut1 (
        .clk(clk), .reset(reset), .si(si1), .en(en1), .rd(rd1),
        .Q(q1), .valid(valid1), .frame_err(ferr1), .overrun(ovr1), .busy(busy1)
    );

    // Monitor for instance 0: an event is a frame_err pulse or a newly
    // presented word (valid rising or Q changing while valid).
    logic       pv0 = 1'b0;
    logic [3:0] pq0 = 4'd0;
    always @(negedge clk) begin
        ev_t a, e;
        if (ferr0 || (valid0 && (!pv0 || q0 != pq0))) begin
            a = '{err: ferr0, q: q0, vld: valid0, ovr: ovr0};
            checks++;
            if (exp0.size() == 0) begin
                failures++;
                $display("FAIL dut0_unexpected_event actual=%b required=none", a);
            end else begin
                e = exp0.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL dut0_event actual err=%b q=%b vld=%b ovr=%b required err=%b q=%b vld=%b ovr=%b",
                             a.err, a.q, a.vld, a.ovr, e.err, e.q, e.vld, e.ovr);
                end
            end
        end
        pv0 = valid0;
        pq0 = q0;
    end

    logic       pv1 = 1'b0;
    logic [3:0] pq1 = 4'd0;
    always @(negedge clk) begin
        ev_t a, e;
        if (ferr1 || (valid1 && (!pv1 || q1 != pq1))) begin
            a = '{err: ferr1, q: q1, vld: valid1, ovr: ovr1};
            checks++;
            if (exp1.size() == 0) begin
                failures++;
                $display("FAIL dut1_unexpected_event actual=%b required=none", a);
            end else begin
                e = exp1.pop_front();
                if (a !== e) begin
                    failures++;
                    $display("FAIL dut1_event actual err=%b q=%b vld=%b ovr=%b required err=%b q=%b vld=%b ovr=%b",
                             a.err, a.q, a.vld, a.ovr, e.err, e.q, e.vld, e.ovr);
                end
            end
        end
        pv1 = valid1;
        pq1 = q1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Sends n bits (bit 0 first), each followed by gap disabled cycles during
    // which si carries the inverted bit. Reports the edge (from the start bit)
    // on which valid was first seen high and the number of busy cycles.
    task automatic send(input int dut, input logic [6:0] bits, input int n, input int gap,
                        input bit rd_last, output int vedge, output int busyc);
        int e;
        vedge = 0;
        busyc = 0;
        e = 0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g <= gap; g++) begin
                if (dut == 0) begin
                    si0 = (g == 0) ? bits[i] : ~bits[i];
                    en0 = (g == 0);
                    rd0 = rd_last && (i == n - 1) && (g == 0);
                end else begin
                    si1 = (g == 0) ? bits[i] : ~bits[i];
                    en1 = (g == 0);
                    rd1 = rd_last && (i == n - 1) && (g == 0);
                end
                tick();
                e++;
                if (vedge == 0 && ((dut == 0) ? valid0 : valid1)) vedge = e;
                if ((dut == 0) ? busy0 : busy1) busyc++;
            end
        end
        si0 = 1'b0; en0 = 1'b0; rd0 = 1'b0;
        si1 = 1'b0; en1 = 1'b0; rd1 = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int ve, bc, wait_cnt;

        // Reset state, with en and rd both asserted to show they are ignored.
        en0 = 1'b1; rd0 = 1'b1; si0 = 1'b1;
        do_reset();
        en0 = 1'b0; rd0 = 1'b0; si0 = 1'b0;
        chk("reset_outputs", {q0, valid0, ferr0, ovr0, busy0}, 8'h00);

        // Basic receive: si 1,1,1,0,1,0 -> Q=1011 on the 6th edge, busy 5 cycles.
        exp0.push_back('{err: 1'b0, q: 4'b1011, vld: 1'b1, ovr: 1'b0});
        send(0, 7'b0_1011_1, 6, 0, 1'b0, ve, bc);
        chk("basic_latency", 8'(ve), 8'd6);
        chk("basic_busy_cycles", 8'(bc), 8'd5);
        chk("basic_ferr", {7'd0, ferr0}, 8'd0);

        // Read clears valid when no word completes.
        rd0 = 1'b1; tick(); rd0 = 1'b0;
        chk("rd_clears_valid", {7'd0, valid0}, 8'd0);

        // Bad stop bit: si 1,0,1,0,1,1 -> single frame_err pulse, Q held.
        exp0.push_back('{err: 1'b1, q: 4'b1011, vld: 1'b0, ovr: 1'b0});
        send(0, 7'b1_1010_1, 6, 0, 1'b0, ve, bc);
        tick();
        chk("bad_stop_pulse_width_and_idle", {6'd0, ferr0, busy0}, 8'd0);

        // Gated sampling: en on every other cycle -> valid on the 11th edge.
        exp0.push_back('{err: 1'b0, q: 4'b1011, vld: 1'b1, ovr: 1'b0});
        send(0, 7'b0_1011_1, 6, 1, 1'b0, ve, bc);
        chk("gated_latency", 8'(ve), 8'd11);
        rd0 = 1'b1; tick(); rd0 = 1'b0;

        // Back-to-back 1011 then 0110 unread -> overrun.
        exp0.push_back('{err: 1'b0, q: 4'b1011, vld: 1'b1, ovr: 1'b0});
        exp0.push_back('{err: 1'b0, q: 4'b0110, vld: 1'b1, ovr: 1'b1});
        send(0, 7'b0_1011_1, 6, 0, 1'b0, ve, bc);
        send(0, 7'b0_0110_1, 6, 0, 1'b0, ve, bc);
        tick();
        chk("overrun_sticky", {7'd0, ovr0}, 8'd1);

        // Same pair with rd on the second completion edge -> no overrun.
        do_reset();
        chk("overrun_cleared_by_reset", {7'd0, ovr0}, 8'd0);
        exp0.push_back('{err: 1'b0, q: 4'b1011, vld: 1'b1, ovr: 1'b0});
        exp0.push_back('{err: 1'b0, q: 4'b0110, vld: 1'b1, ovr: 1'b0});
        send(0, 7'b0_1011_1, 6, 0, 1'b0, ve, bc);
        send(0, 7'b0_0110_1, 6, 0, 1'b1, ve, bc);
        chk("same_edge_read", {q0, 2'b00, valid0, ovr0}, 8'b0110_00_1_0);
        rd0 = 1'b1; tick();
        chk("read_after_same_edge", {7'd0, valid0}, 8'd0);
        tick(); rd0 = 1'b0;
        chk("rd_without_valid", {q0, 2'b00, valid0, ovr0}, 8'b0110_00_0_0);

        // Reset after the 2nd data bit aborts the frame quietly.
        send(0, 7'b000_101, 3, 0, 1'b0, ve, bc);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_frame_reset", {q0, valid0, ferr0, ovr0, busy0}, 8'h00);
        tick();
        chk("mid_frame_reset_no_err", {7'd0, ferr0}, 8'd0);
        exp0.push_back('{err: 1'b0, q: 4'b0101, vld: 1'b1, ovr: 1'b0});
        send(0, 7'b0_0101_1, 6, 0, 1'b0, ve, bc);

        // Parity instance: good parity accepted on the 7th edge.
        exp1.push_back('{err: 1'b0, q: 4'b1011, vld: 1'b1, ovr: 1'b0});
        send(1, 7'b0_1_1011_1, 7, 0, 1'b0, ve, bc);
        chk("parity_latency", 8'(ve), 8'd7);
        // Wrong parity bit: error pulse, Q and valid unchanged.
        exp1.push_back('{err: 1'b1, q: 4'b1011, vld: 1'b1, ovr: 1'b0});
        send(1, 7'b0_0_1011_1, 7, 0, 1'b0, ve, bc);
        // Even-parity data with parity 0 is accepted; unread word -> overrun.
        exp1.push_back('{err: 1'b0, q: 4'b0110, vld: 1'b1, ovr: 1'b1});
        send(1, 7'b0_0_0110_1, 7, 0, 1'b0, ve, bc);
        // Good data with a bad stop bit is rejected as well.
        exp1.push_back('{err: 1'b1, q: 4'b0110, vld: 1'b1, ovr: 1'b1});
        send(1, 7'b1_1_0001_1, 7, 0, 1'b0, ve, bc);

        // Drain the scoreboards within a bounded number of cycles.
        wait_cnt = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        tick();
        checks++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d/%0d pending required=0/0", exp0.size(), exp1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
